// File: rtl/fc_pkg.sv
// Shared types and width helpers for the fc layer output-side function units.
package fc_pkg;

    typedef enum logic [1:0] {IDLE, RD, DRAIN, OUT} fc_state_e;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    // $clog2 floored at 1 so single-entry dimensions still get a real bit
    function automatic int clogw(input int x);
        return (x <= 1) ? 1 : $clog2(x);
    endfunction

    function automatic int acc_width(input int dsz, input int v_tiles, input int bpw);
        return dsz + $clog2(v_tiles) + bpw + 1;
    endfunction

endpackage

// File: rtl/fc_accum_func_if.sv
// CIM output-buffer read port plus next-layer input-buffer write port.
interface fc_accum_func_if #(
    parameter int DW  = 8,
    parameter int V   = 1,
    parameter int H   = 1,
    parameter int RAW = 9,
    parameter int OAW = 4,
    parameter int ODW = 8
);
    logic [V-1:0][H-1:0][DW-1:0] i_data;
    logic [RAW-1:0]              o_cim_rd_addr;
    logic                        i_next_busy;
    logic                        o_we;
    logic [OAW-1:0]              o_addr;
    logic [ODW-1:0]              o_data;

    modport master (
        input  i_data, i_next_busy,
        output o_cim_rd_addr, o_we, o_addr, o_data
    );

    modport slave (
        output i_data, i_next_busy,
        input  o_cim_rd_addr, o_we, o_addr, o_data
    );
endinterface

// File: rtl/fc_requant.sv
// Combinational requantiser: arithmetic right shift, optional ReLU, signed saturation.
module fc_requant #(
    parameter int ACC_WIDTH            = 18,
    parameter int OUTPUT_DATATYPE_SIZE = 8,
    parameter int SHIFT_W              = $clog2(ACC_WIDTH)
) (
    input  logic signed [ACC_WIDTH-1:0]            acc,
    input  logic        [SHIFT_W-1:0]              shift,
    input  logic                                   relu,
    output logic signed [OUTPUT_DATATYPE_SIZE-1:0] res
);
    logic signed [ACC_WIDTH-1:0] sh_v, rl_v;

    always_comb begin
        sh_v = acc >>> shift;
        rl_v = (relu && sh_v[ACC_WIDTH-1]) ? '0 : sh_v;
    end

    generate
        if (OUTPUT_DATATYPE_SIZE >= ACC_WIDTH) begin : g_ext
            assign res = OUTPUT_DATATYPE_SIZE'(rl_v);
        end else begin : g_sat
            localparam logic signed [ACC_WIDTH-1:0] MAXV = ACC_WIDTH'((2 ** (OUTPUT_DATATYPE_SIZE - 1)) - 1);
            localparam logic signed [ACC_WIDTH-1:0] MINV = ACC_WIDTH'(-(2 ** (OUTPUT_DATATYPE_SIZE - 1)));
            always_comb begin
                if (rl_v > MAXV)      res = MAXV[OUTPUT_DATATYPE_SIZE-1:0];
                else if (rl_v < MINV) res = MINV[OUTPUT_DATATYPE_SIZE-1:0];
                else                  res = rl_v[OUTPUT_DATATYPE_SIZE-1:0];
            end
        end
    endgenerate
endmodule

// File: rtl/fc_accum_func.sv
// FC output function unit: reads bit-sliced CIM columns, shift-accumulates with a
// negative MSB slice, requantises and writes each neuron to the next layer's ibuf.
module fc_accum_func
    import fc_pkg::*;
#(
    parameter int INPUT_SIZE           = 500,
    parameter int OUTPUT_SIZE          = 10,
    parameter int XBAR_SIZE            = 512,
    parameter int DATATYPE_SIZE        = 8,
    parameter int BITS_PER_WEIGHT      = 8,
    parameter int OUTPUT_DATATYPE_SIZE = 8,
    parameter int V_CIM_TILES          = ceil_div(INPUT_SIZE, XBAR_SIZE),
    parameter int H_CIM_TILES          = ceil_div(OUTPUT_SIZE * BITS_PER_WEIGHT, XBAR_SIZE),
    parameter int ACC_WIDTH            = acc_width(DATATYPE_SIZE, V_CIM_TILES, BITS_PER_WEIGHT),
    localparam int SHIFT_W             = clogw(ACC_WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    input  logic [SHIFT_W-1:0] i_shift,
    input  logic               i_relu,
    output logic               o_busy,
    output logic               o_done,
    fc_accum_func_if.master    bus
);
    localparam int RAW = clogw(XBAR_SIZE);
    localparam int OAW = clogw(OUTPUT_SIZE);
    localparam int HW  = clogw(H_CIM_TILES);
    localparam int BW  = clogw(BITS_PER_WEIGHT);
    localparam int SW  = DATATYPE_SIZE + clogw(V_CIM_TILES);
    localparam logic [BW-1:0]  B_LAST = BW'(BITS_PER_WEIGHT - 1);
    localparam logic [OAW-1:0] N_LAST = OAW'(OUTPUT_SIZE - 1);
    localparam logic [RAW-1:0] A_LAST = RAW'(XBAR_SIZE - 1);

    fc_state_e state, nxt;

    logic [OAW-1:0] n;
    logic [BW-1:0]  b, rd_b;
    logic [HW-1:0]  h, rd_h;
    logic [RAW-1:0] rd_addr;
    logic           rd_vld;
    logic [SW-1:0]  slice;
    logic [SHIFT_W-1:0] shift_q;
    logic           relu_q;
    logic signed [ACC_WIDTH-1:0] acc, acc_nxt;
    logic signed [OUTPUT_DATATYPE_SIZE-1:0] rq;
    logic start_ok, issue, last_b, last_n, fire, adv;

    assign bus.o_cim_rd_addr = rd_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (i_start) nxt = RD;
            RD:      if (last_b) nxt = DRAIN;
            DRAIN:   nxt = OUT;
            OUT:     if (fire) nxt = last_n ? IDLE : RD;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        start_ok = (state == IDLE) && i_start;
        issue    = (state == RD);
        last_b   = (b == B_LAST);
        last_n   = (n == N_LAST);
        fire     = (state == OUT) && !bus.i_next_busy;
        adv      = (issue && !last_b) || (fire && !last_n);
    end

    // rd_b/rd_h describe the column whose data is on i_data this cycle
    always_comb begin
        slice = '0;
        for (int v = 0; v < V_CIM_TILES; v++)
            slice = slice + SW'(bus.i_data[v][rd_h]);
        if (rd_b == B_LAST) acc_nxt = acc - (ACC_WIDTH'(slice) << rd_b);
        else                acc_nxt = acc + (ACC_WIDTH'(slice) << rd_b);
    end

    fc_requant #(
        .ACC_WIDTH            (ACC_WIDTH),
        .OUTPUT_DATATYPE_SIZE (OUTPUT_DATATYPE_SIZE),
        .SHIFT_W              (SHIFT_W)
    ) u_requant (
        .acc   (acc_nxt),
        .shift (shift_q),
        .relu  (relu_q),
        .res   (rq)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n          <= '0;
            b          <= '0;
            h          <= '0;
            rd_addr    <= '0;
            rd_vld     <= 1'b0;
            rd_b       <= '0;
            rd_h       <= '0;
            acc        <= '0;
            shift_q    <= '0;
            relu_q     <= 1'b0;
            bus.o_we   <= 1'b0;
            bus.o_addr <= '0;
            bus.o_data <= '0;
            o_done     <= 1'b0;
            o_busy     <= 1'b0;
        end else begin
            rd_vld   <= issue;
            rd_b     <= b;
            rd_h     <= h;
            bus.o_we <= fire;
            o_done   <= fire && last_n;
            o_busy   <= (nxt != IDLE) || (fire && last_n);
            if (start_ok) begin
                n       <= '0;
                b       <= '0;
                h       <= '0;
                rd_addr <= '0;
                acc     <= '0;
                shift_q <= i_shift;
                relu_q  <= i_relu;
            end else begin
                if (fire)        acc <= '0;
                else if (rd_vld) acc <= acc_nxt;
                if (issue && !last_b) b <= b + 1'b1;
                else if (fire)        b <= '0;
                if (fire && !last_n) n <= n + 1'b1;
                // global column walks linearly across neurons; wrap into the next tile
                if (adv) begin
                    if (rd_addr == A_LAST) begin
                        rd_addr <= '0;
                        h       <= h + 1'b1;
                    end else begin
                        rd_addr <= rd_addr + 1'b1;
                    end
                end
                // result captured as the last slice lands; held through OUT and the write
                if (state == DRAIN) begin
                    bus.o_data <= rq;
                    bus.o_addr <= n;
                end
            end
        end
    end
endmodule

// File: doc/fc_accum_func.md
Name: fc_accum_func

Overview:
- Output-side function unit for an FC layer on bit-sliced CIM crossbars; parametrised successor to the fixed fc_func path.
- Each output neuron's weight is spread over BITS_PER_WEIGHT crossbar columns, and each column may be split across V_CIM_TILES vertical tiles.
- The block reads every column's partial sums from all vertical tiles, then shift-accumulates them with the MSB slice negative (two's-complement weights).
- It then applies a runtime right-shift, optional ReLU and saturation, and writes each result into the next layer's input buffer under backpressure.

Parameters:
- INPUT_SIZE, 500, layer input count.
- OUTPUT_SIZE, 10, output neuron count.
- XBAR_SIZE, 512, crossbar rows/columns per tile.
- DATATYPE_SIZE, 8, width of one CIM output-buffer entry (unsigned).
- BITS_PER_WEIGHT, 8, columns per neuron; column BITS_PER_WEIGHT-1 is the sign slice.
- OUTPUT_DATATYPE_SIZE, 8, signed result width.
- V_CIM_TILES, ceil(INPUT_SIZE/XBAR_SIZE), vertical tiles.
- H_CIM_TILES, ceil(OUTPUT_SIZE*BITS_PER_WEIGHT/XBAR_SIZE), horizontal tiles.
- ACC_WIDTH, DATATYPE_SIZE+$clog2(V_CIM_TILES)+BITS_PER_WEIGHT+1, signed accumulator width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- i_start  in  1  pulse: CIM compute finished, begin readout.
- i_shift  in  $clog2(ACC_WIDTH)  arithmetic right-shift amount, sampled on accepted i_start.
- i_relu  in  1  ReLU enable, sampled on accepted i_start.
- i_data  in  DATATYPE_SIZE x [V_CIM_TILES][H_CIM_TILES]  CIM output-buffer read data, valid 1 cycle after o_cim_rd_addr.
- o_cim_rd_addr  out  $clog2(XBAR_SIZE)  column index local to its tile.
- i_next_busy  in  1  next layer cannot accept a write.
- o_we  out  1  next-layer ibuf write strobe.
- o_addr  out  $clog2(OUTPUT_SIZE)  next-layer ibuf address, equal to the neuron index.
- o_data  out  OUTPUT_DATATYPE_SIZE  requantised result.
- o_busy  out  1  high from the cycle after an accepted start until the cycle after the final write.
- o_done  out  1  one-cycle pulse with the final write.

Behaviour:
- Reset: state IDLE; o_busy, o_we, o_done, o_addr, o_data, o_cim_rd_addr, accumulator and counters all 0.
- Reset is honoured mid-operation: abort to IDLE, no further writes.
- Global column index: c = n*BITS_PER_WEIGHT + b.
  - Tile select h = c / XBAR_SIZE.
  - o_cim_rd_addr = c % XBAR_SIZE.
  - h and b are registered alongside the read so they align with the 1-cycle data latency.
- Slice value per column: S = sum over v of i_data[v][h], zero-extended.
  - b < BITS_PER_WEIGHT-1: acc += S << b.
  - b = BITS_PER_WEIGHT-1: acc -= S << b.
- States:
  - IDLE: i_start accepted only here. Latch i_shift and i_relu, set n=0, b=0, acc=0, go to RD. i_start in any other state is ignored.
  - RD: drive the address for (n,b) each cycle and accumulate the column issued the previous cycle. After issuing b=BITS_PER_WEIGHT-1, go to DRAIN.
  - DRAIN: accumulate the last slice; go to OUT.
  - OUT: o_data = sat(relu(acc >>> shift)); o_addr = n.
    - While i_next_busy=1: o_we=0, o_data and o_addr held, no CIM reads.
    - When i_next_busy=0: o_we=1 for one cycle.
    - If n = OUTPUT_SIZE-1: o_done=1 in the same cycle, then IDLE.
    - Otherwise n++, b=0, acc=0, go to RD.
- Requantisation:
  - Arithmetic shift first.
  - ReLU maps negative values to 0.
  - Saturate to [-2^(OUTPUT_DATATYPE_SIZE-1), 2^(OUTPUT_DATATYPE_SIZE-1)-1].
- Throughput with no backpressure: BITS_PER_WEIGHT+2 cycles per neuron. Total latency from start to o_done = OUTPUT_SIZE*(BITS_PER_WEIGHT+2) cycles.
- o_we and o_done are registered outputs. o_busy deasserts the cycle after o_done.

Decomposition:
- Package fc_pkg:
  - ceil_div function.
  - State enum {IDLE, RD, DRAIN, OUT}.
  - Derived-width localparams shared across fc blocks.
- Sub-module fc_requant: combinational shift, ReLU and saturation, parametrised on ACC_WIDTH and OUTPUT_DATATYPE_SIZE, reusable by later layer types.

Test Plan:
Common config: INPUT_SIZE=6, XBAR_SIZE=4, OUTPUT_SIZE=3, BITS_PER_WEIGHT=2, DATATYPE_SIZE=4, OUTPUT_DATATYPE_SIZE=8 (gives V=2, H=2).
- Sign handling: all i_data=1, shift 0, relu off -> per neuron acc = 2 - 2*2 = -2. Expect three writes, o_addr 0,1,2, o_data 0xFE; o_done with the third write at cycle 12 after start. Repeat with relu on -> o_data 0x00.
- Shift: bit-0 columns 7 in both tiles, bit-1 columns 0, shift 1 -> 14>>>1 = 7 at every address.
- Address mapping: o_cim_rd_addr sequence 0,1,2,3,0,1. Neuron 2 takes its data from h=1, checked by distinct per-tile values.
- Saturation: second config with OUTPUT_DATATYPE_SIZE=4 and bit-0 columns 15 -> acc 30 -> o_data 7. Sign columns 15 and bit-0 0 -> acc -60 -> o_data 0x8 (-8).
- Backpressure: hold i_next_busy high 5 cycles in OUT for neuron 1 -> o_we low, o_data and o_addr stable, o_cim_rd_addr unchanged. Write occurs the first cycle i_next_busy=0.
- Control: i_start pulsed during RD -> ignored, exactly 3 writes. rst asserted mid-RD -> all outputs 0 immediately, no writes. A fresh i_start then completes normally.
